// File: rtl/auto_player_pkg.sv
// ============================================================================
// Package : auto_player_pkg
// Brief   : Shared note codes, sequencer state encoding and note->LED decode.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package auto_player_pkg;

    localparam logic [3:0] REST     = 4'h0;
    localparam logic [3:0] END_MARK = 4'hF;

    localparam logic [3:0] NOTE_DO  = 4'd1;
    localparam logic [3:0] NOTE_RE  = 4'd2;
    localparam logic [3:0] NOTE_MI  = 4'd3;
    localparam logic [3:0] NOTE_FA  = 4'd4;
    localparam logic [3:0] NOTE_SOL = 4'd5;
    localparam logic [3:0] NOTE_LA  = 4'd6;
    localparam logic [3:0] NOTE_SI  = 4'd7;

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_FETCH = 3'd1,
        S_PLAY  = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [6:0] note_to_led(input logic [3:0] note);
        logic [6:0] led;
        led = 7'b0000000;
        case (note)
            NOTE_DO:  led = 7'b0000001;
            NOTE_RE:  led = 7'b0000010;
            NOTE_MI:  led = 7'b0000100;
            NOTE_FA:  led = 7'b0001000;
            NOTE_SOL: led = 7'b0010000;
            NOTE_LA:  led = 7'b0100000;
            NOTE_SI:  led = 7'b1000000;
            default:  led = 7'b0000000;
        endcase
        return led;
    endfunction

endpackage

`default_nettype wire

// File: rtl/song_edge_sel.sv
// ============================================================================
// Module  : song_edge_sel
// Brief   : Next/prev rising-edge detect driving a wrapping song index.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module song_edge_sel #(
    parameter int NUM_SONGS = 3,
    parameter int SONG_W    = $clog2(NUM_SONGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              song_next,
    input  logic              song_prev,
    output logic [SONG_W-1:0] song_idx,
    output logic              sel_valid
);

    localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);

    logic              next_hist_q, next_hist_d;
    logic              prev_hist_q, prev_hist_d;
    logic              armed_q,     armed_d;
    logic [SONG_W-1:0] idx_q,       idx_d;
    logic              rise_next;
    logic              rise_prev;

    // Detection is held off for the first cycle after reset so the history
    // can pick up a level that was already high; that level is not an edge.
    always_comb begin
        next_hist_d = song_next;
        prev_hist_d = song_prev;
        armed_d     = 1'b1;
        rise_next   = armed_q & song_next & ~next_hist_q;
        rise_prev   = armed_q & song_prev & ~prev_hist_q;
        sel_valid   = rise_next ^ rise_prev;
        idx_d       = idx_q;
        if (rise_next && !rise_prev) begin
            idx_d = (idx_q == LAST_SONG) ? '0 : idx_q + 1'b1;
        end else if (rise_prev && !rise_next) begin
            idx_d = (idx_q == '0) ? LAST_SONG : idx_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            next_hist_q <= 1'b0;
            prev_hist_q <= 1'b0;
            armed_q     <= 1'b0;
            idx_q       <= '0;
        end else begin
            next_hist_q <= next_hist_d;
            prev_hist_q <= prev_hist_d;
            armed_q     <= armed_d;
            idx_q       <= idx_d;
        end
    end

    assign song_idx = idx_q;

endmodule

`default_nettype wire

// File: rtl/auto_player_seq.sv
// ============================================================================
// Module  : auto_player_seq
// Brief   : Auto-play sequencer stepping stored songs from a registered ROM.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module auto_player_seq
    import auto_player_pkg::*;
#(
    parameter int NUM_SONGS  = 3,
    parameter int SONG_LEN   = 56,
    parameter int UNIT_TICKS = 10000000,
    parameter int GAP_TICKS  = 0,
    parameter int DUR_W      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         song_next,
    input  logic                         song_prev,
    input  logic                         pause,
    input  logic                         loop_en,
    output logic [$clog2(NUM_SONGS)-1:0] rom_song,
    output logic [$clog2(SONG_LEN)-1:0]  rom_pos,
    input  logic [3:0]                   rom_note,
    input  logic [1:0]                   rom_oct,
    input  logic [DUR_W-1:0]             rom_dur,
    output logic [3:0]                   note_out,
    output logic [1:0]                   octave_out,
    output logic [6:0]                   led_out,
    output logic [$clog2(NUM_SONGS)-1:0] song_idx,
    output logic                         playing,
    output logic                         song_done
);

    localparam int SONG_W   = $clog2(NUM_SONGS);
    localparam int POS_W    = $clog2(SONG_LEN);
    localparam int CNT_W    = $clog2((2 ** DUR_W) * UNIT_TICKS);
    localparam int GAP_W    = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int GAP_LOAD = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(SONG_LEN - 1);
    localparam logic [CNT_W-1:0] UNIT_C   = CNT_W'(UNIT_TICKS);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_LOAD[GAP_W-1:0];

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos_q,   pos_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [GAP_W-1:0]   gap_q,   gap_d;
    logic [3:0]         note_q,  note_d;
    logic [1:0]         oct_q,   oct_d;
    logic [6:0]         led_q,   led_d;
    logic               done_q,  done_d;

    logic [SONG_W-1:0]  sel_idx;
    logic               sel_valid;
    logic               advance;
    logic               end_of_song;
    logic [CNT_W-1:0]   dur_eff;
    logic               run_paused;

    song_edge_sel #(
        .NUM_SONGS (NUM_SONGS),
        .SONG_W    (SONG_W)
    ) u_song_edge_sel (
        .clk       (clk),
        .reset     (reset),
        .song_next (song_next),
        .song_prev (song_prev),
        .song_idx  (sel_idx),
        .sel_valid (sel_valid)
    );

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        note_d      = note_q;
        oct_d       = oct_q;
        led_d       = led_q;
        done_d      = 1'b0;
        advance     = 1'b0;
        end_of_song = 1'b0;
        // A stored duration of zero still plays for one unit.
        dur_eff     = (rom_dur == '0) ? CNT_W'(1) : CNT_W'(rom_dur);

        case (state_q)
            S_LOAD: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (rom_note == END_MARK) begin
                    end_of_song = 1'b1;
                end else begin
                    cnt_d   = dur_eff * UNIT_C - 1'b1;
                    note_d  = rom_note;
                    oct_d   = rom_oct;
                    led_d   = note_to_led(rom_note);
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (!pause) begin
                    if (cnt_q == '0) begin
                        note_d = REST;
                        led_d  = '0;
                        if (GAP_TICKS == 0) begin
                            advance = 1'b1;
                        end else begin
                            gap_d   = GAP_INIT;
                            state_d = S_GAP;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (!pause) begin
                    if (gap_q == '0) begin
                        advance = 1'b1;
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        if (advance) begin
            if (pos_q == LAST_POS) begin
                end_of_song = 1'b1;
            end else begin
                pos_d   = pos_q + 1'b1;
                state_d = S_LOAD;
            end
        end

        if (end_of_song) begin
            done_d  = 1'b1;
            pos_d   = '0;
            state_d = loop_en ? S_LOAD : S_DONE;
        end

        // A song change overrides whatever step the sequencer was about to take.
        if (sel_valid) begin
            state_d = S_LOAD;
            pos_d   = '0;
            cnt_d   = '0;
            gap_d   = '0;
            note_d  = REST;
            led_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LOAD;
            pos_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            note_q  <= REST;
            oct_q   <= '0;
            led_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            note_q  <= note_d;
            oct_q   <= oct_d;
            led_q   <= led_d;
            done_q  <= done_d;
        end
    end

    assign run_paused = pause && ((state_q == S_PLAY) || (state_q == S_GAP));

    assign rom_song   = sel_idx;
    assign rom_pos    = pos_q;
    assign song_idx   = sel_idx;
    assign note_out   = run_paused ? REST : note_q;
    assign led_out    = run_paused ? 7'b0000000 : led_q;
    assign octave_out = oct_q;
    assign playing    = ((state_q == S_PLAY) || (state_q == S_GAP)) && !pause;
    assign song_done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_auto_player_seq.sv
// ============================================================================
// Module  : tb_auto_player_seq
// Brief   : Directed bench for auto_player_seq with a behavioural registered ROM.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_auto_player_seq;

    localparam int NUM_SONGS  = 3;
    localparam int SONG_LEN   = 8;
    localparam int UNIT_TICKS = 4;
    localparam int GAP_TICKS  = 2;
    localparam int DUR_W      = 4;

    logic       clk;
    logic       reset;
    logic       song_next;
    logic       song_prev;
    logic       pause;
    logic       loop_en;
    logic [1:0] rom_song;
    logic [2:0] rom_pos;
    logic [3:0] rom_note;
    logic [1:0] rom_oct;
    logic [3:0] rom_dur;
    logic [3:0] note_out;
    logic [1:0] octave_out;
    logic [6:0] led_out;
    logic [1:0] song_idx;
    logic       playing;
    logic       song_done;

    auto_player_seq #(
        .NUM_SONGS  (NUM_SONGS),
        .SONG_LEN   (SONG_LEN),
        .UNIT_TICKS (UNIT_TICKS),
        .GAP_TICKS  (GAP_TICKS),
        .DUR_W      (DUR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .song_next  (song_next),
        .song_prev  (song_prev),
        .pause      (pause),
        .loop_en    (loop_en),
        .rom_song   (rom_song),
        .rom_pos    (rom_pos),
        .rom_note   (rom_note),
        .rom_oct    (rom_oct),
        .rom_dur    (rom_dur),
        .note_out   (note_out),
        .octave_out (octave_out),
        .led_out    (led_out),
        .song_idx   (song_idx),
        .playing    (playing),
        .song_done  (song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural registered ROM: data follows the address by one clock.
    logic [3:0] rn [3][8];
    logic [1:0] ro [3][8];
    logic [3:0] rd [3][8];

    always @(posedge clk) begin
        if (rom_song < 2'd3) begin
            rom_note <= rn[rom_song][rom_pos];
            rom_oct  <= ro[rom_song][rom_pos];
            rom_dur  <= rd[rom_song][rom_pos];
        end else begin
            rom_note <= 4'hF;
            rom_oct  <= 2'd0;
            rom_dur  <= 4'd0;
        end
    end

    typedef struct {
        int         n;
        logic       pause;
        logic       loop_en;
        logic [3:0] note;
        logic [1:0] oct;
        logic [6:0] led;
        logic       play;
        logic       done;
        logic [2:0] pos;
    } vec_t;

    vec_t tbl [21];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(input int n, input int p, input int l, input int note,
                                input int oct, input int led, input int pl, input int dn,
                                input int pos);
        vec_t v;
        v.n       = n;
        v.pause   = 1'(p);
        v.loop_en = 1'(l);
        v.note    = 4'(note);
        v.oct     = 2'(oct);
        v.led     = 7'(led);
        v.play    = 1'(pl);
        v.done    = 1'(dn);
        v.pos     = 3'(pos);
        return v;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int cyc;
        int maxpos;
        int bad;
        int found;
        int ledbad;
        logic [6:0] exp_led;

        for (int s = 0; s < 3; s++) begin
            for (int p = 0; p < 8; p++) begin
                rn[s][p] = 4'hF;
                ro[s][p] = 2'd0;
                rd[s][p] = 4'd0;
            end
        end
        // Song 0: 1/3/5 with durations 1,2,0 then end mark
        rn[0][0] = 4'd1; ro[0][0] = 2'd1; rd[0][0] = 4'd1;
        rn[0][1] = 4'd3; ro[0][1] = 2'd2; rd[0][1] = 4'd2;
        rn[0][2] = 4'd5; ro[0][2] = 2'd3; rd[0][2] = 4'd0;
        // Song 1: eight notes, no end mark
        for (int p = 0; p < 8; p++) begin
            rd[1][p] = 4'd1;
            ro[1][p] = 2'd0;
        end
        rn[1][0] = 4'd2; rn[1][1] = 4'd4; rn[1][2] = 4'd6; rn[1][3] = 4'd7;
        rn[1][4] = 4'd1; rn[1][5] = 4'd2; rn[1][6] = 4'd3; rn[1][7] = 4'd4;
        // Song 2
        rn[2][0] = 4'd6; ro[2][0] = 2'd1; rd[2][0] = 4'd3;
        rn[2][1] = 4'd4; ro[2][1] = 2'd2; rd[2][1] = 4'd1;

        // n, pause, loop, note, oct, led, playing, done, pos
        tbl[0]  = mk(1, 0, 1, 0, 0, 7'h00, 0, 0, 0);  // LOAD after reset
        tbl[1]  = mk(1, 0, 1, 0, 0, 7'h00, 0, 0, 0);  // FETCH
        tbl[2]  = mk(4, 0, 1, 1, 1, 7'h01, 1, 0, 0);  // note1, 1 unit
        tbl[3]  = mk(2, 0, 1, 0, 1, 7'h00, 1, 0, 0);  // gap
        tbl[4]  = mk(2, 0, 1, 0, 1, 7'h00, 0, 0, 1);  // LOAD/FETCH pos1
        tbl[5]  = mk(8, 0, 1, 3, 2, 7'h04, 1, 0, 1);  // note3, 2 units
        tbl[6]  = mk(2, 0, 1, 0, 2, 7'h00, 1, 0, 1);
        tbl[7]  = mk(2, 0, 1, 0, 2, 7'h00, 0, 0, 2);
        tbl[8]  = mk(4, 0, 1, 5, 3, 7'h10, 1, 0, 2);  // note5, dur 0 -> 1 unit
        tbl[9]  = mk(2, 0, 1, 0, 3, 7'h00, 1, 0, 2);
        tbl[10] = mk(2, 0, 1, 0, 3, 7'h00, 0, 0, 3);  // end mark fetched
        tbl[11] = mk(1, 0, 1, 0, 3, 7'h00, 0, 1, 0);  // song_done, wrap
        tbl[12] = mk(1, 0, 1, 0, 3, 7'h00, 0, 0, 0);
        tbl[13] = mk(4, 0, 1, 1, 1, 7'h01, 1, 0, 0);
        tbl[14] = mk(2, 0, 1, 0, 1, 7'h00, 1, 0, 0);
        tbl[15] = mk(2, 1, 1, 0, 1, 7'h00, 0, 0, 1);  // pause during LOAD/FETCH
        tbl[16] = mk(2, 0, 1, 3, 2, 7'h04, 1, 0, 1);
        tbl[17] = mk(3, 1, 1, 0, 2, 7'h00, 0, 0, 1);  // paused mid note
        tbl[18] = mk(6, 0, 1, 3, 2, 7'h04, 1, 0, 1);  // remaining 6 of 8
        tbl[19] = mk(2, 0, 1, 0, 2, 7'h00, 1, 0, 1);
        tbl[20] = mk(2, 0, 1, 0, 2, 7'h00, 0, 0, 2);

        reset     = 1'b0;
        song_next = 1'b0;
        song_prev = 1'b0;
        pause     = 1'b0;
        loop_en   = 1'b1;
        rom_note  = 4'd0;
        rom_oct   = 2'd0;
        rom_dur   = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        chk("reset song_idx", int'(song_idx), 0);
        chk("reset rom_song", int'(rom_song), 0);

        for (int r = 0; r < 21; r++) begin
            for (int c = 0; c < tbl[r].n; c++) begin
                pause   = tbl[r].pause;
                loop_en = tbl[r].loop_en;
                #1;
                chk($sformatf("row%0d.%0d note", r, c), int'(note_out), int'(tbl[r].note));
                chk($sformatf("row%0d.%0d oct", r, c), int'(octave_out), int'(tbl[r].oct));
                chk($sformatf("row%0d.%0d led", r, c), int'(led_out), int'(tbl[r].led));
                chk($sformatf("row%0d.%0d playing", r, c), int'(playing), int'(tbl[r].play));
                chk($sformatf("row%0d.%0d done", r, c), int'(song_done), int'(tbl[r].done));
                chk($sformatf("row%0d.%0d pos", r, c), int'(rom_pos), int'(tbl[r].pos));
                @(posedge clk);
                #1;
            end
        end
        pause = 1'b0;

        // One-shot: finish song 0 and park in DONE
        loop_en = 1'b0;
        cyc = 0;
        while (song_done !== 1'b1 && cyc < 40) begin
            step(1);
            cyc++;
        end
        chk("oneshot done pulse", int'(song_done), 1);
        chk("oneshot pos cleared", int'(rom_pos), 0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (note_out !== 4'd0 || playing !== 1'b0 || song_done !== 1'b0 || led_out !== 7'd0)
                bad++;
        end
        chk("done held quiet", bad, 0);

        song_next = 1'b1;
        step(1);
        chk("next from done idx", int'(song_idx), 1);
        chk("next from done pos", int'(rom_pos), 0);
        song_next = 1'b0;
        step(2);
        chk("song1 pos0 note", int'(note_out), 2);
        chk("song1 pos0 led", int'(led_out), 7'h02);
        chk("song1 pos0 playing", int'(playing), 1);

        // Full 8-note song, no end mark: done 64 cycles after LOAD of pos0
        loop_en = 1'b1;
        cyc = 0;
        maxpos = 0;
        ledbad = 0;
        while (song_done !== 1'b1 && cyc < 100) begin
            if (int'(rom_pos) > maxpos) maxpos = int'(rom_pos);
            if (note_out != 4'd0) begin
                exp_led = 7'd1 << (note_out - 4'd1);
                if (led_out !== exp_led) ledbad++;
            end
            step(1);
            cyc++;
        end
        chk("song1 done latency", cyc, 62);
        chk("song1 max pos", maxpos, 7);
        chk("song1 wrap pos", int'(rom_pos), 0);
        chk("song1 led one-hot", ledbad, 0);
        step(2);
        chk("song1 replay note", int'(note_out), 2);

        // Song selection edges
        song_prev = 1'b1;
        step(1);
        chk("prev 1->0", int'(song_idx), 0);
        song_prev = 1'b0;
        step(1);
        song_prev = 1'b1;
        step(1);
        chk("prev 0->2 wrap", int'(song_idx), 2);
        song_prev = 1'b0;
        step(1);
        song_next = 1'b1;
        song_prev = 1'b1;
        step(1);
        chk("next+prev ignored", int'(song_idx), 2);
        song_next = 1'b0;
        song_prev = 1'b0;
        step(1);
        song_next = 1'b1;
        step(1);
        chk("next 2->0 wrap", int'(song_idx), 0);
        song_next = 1'b0;

        // Edge during GAP of pos1 restarts at pos0
        cyc = 0;
        found = 0;
        while (found == 0 && cyc < 40) begin
            if (playing === 1'b1 && note_out === 4'd0 && rom_pos === 3'd1) found = 1;
            else begin
                step(1);
                cyc++;
            end
        end
        chk("reach gap pos1", found, 1);
        chk("gap octave held", int'(octave_out), 2);
        song_next = 1'b1;
        step(1);
        chk("gap select idx", int'(song_idx), 1);
        chk("gap select pos", int'(rom_pos), 0);
        chk("gap select note", int'(note_out), 0);
        chk("gap select playing", int'(playing), 0);
        song_next = 1'b0;
        step(2);
        chk("gap select replay", int'(note_out), 2);

        // Asynchronous reset mid-PLAY of song 1, song_next held high through release
        step(1);
        song_next = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        chk("async rst note", int'(note_out), 0);
        chk("async rst oct", int'(octave_out), 0);
        chk("async rst led", int'(led_out), 0);
        chk("async rst playing", int'(playing), 0);
        chk("async rst done", int'(song_done), 0);
        chk("async rst idx", int'(song_idx), 0);
        chk("async rst pos", int'(rom_pos), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(2);
        chk("post rst note", int'(note_out), 1);
        chk("post rst led", int'(led_out), 7'h01);
        chk("post rst oct", int'(octave_out), 1);
        chk("held level not edge", int'(song_idx), 0);
        song_next = 1'b0;
        step(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
